// File: rtl/chip8_mem_gfx_if.sv
// CPU-facing bus of the CHIP-8 memory/graphics back end.
// Carries the shared memory port, the BCD converter and the draw-engine controls.
interface chip8_mem_gfx_if;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic          mem_read;
  logic [AW-1:0] mem_read_idx;
  logic [DW-1:0] mem_read_byte;
  logic          mem_read_ack;
  logic          mem_write;
  logic [AW-1:0] mem_write_idx;
  logic [DW-1:0] mem_write_byte;

  logic [DW-1:0] bcd_in;
  logic [1:0]    bcd_1;
  logic [3:0]    bcd_2;
  logic [3:0]    bcd_3;

  logic          draw;
  logic [AW-1:0] addr;
  logic [3:0]    lines;
  logic [5:0]    x;
  logic [4:0]    y;
  logic          busy;
  logic          collision;

  modport master (
    output mem_read, mem_read_idx, mem_write, mem_write_idx, mem_write_byte,
    output bcd_in, draw, addr, lines, x, y,
    input  mem_read_byte, mem_read_ack, bcd_1, bcd_2, bcd_3, busy, collision
  );

  modport slave (
    input  mem_read, mem_read_idx, mem_write, mem_write_idx, mem_write_byte,
    input  bcd_in, draw, addr, lines, x, y,
    output mem_read_byte, mem_read_ack, bcd_1, bcd_2, bcd_3, busy, collision
  );
endinterface

// File: rtl/chip8_mem_gfx.sv
// CHIP-8 memory and graphics back end: 4 KiB RAM with hex font, BCD converter,
// and an XOR sprite-draw engine operating on the frame buffer held in RAM.
module chip8_mem_gfx #(
  parameter logic [11:0] FONT_BASE   = 12'h030,
  parameter logic [11:0] SCREEN_BASE = 12'h100
) (
  input logic            clk,
  input logic            rst_n,
  chip8_mem_gfx_if.slave bus
);

  localparam int unsigned AW       = 12;
  localparam int unsigned DW       = 8;
  localparam int unsigned DEPTH    = 4096;
  localparam int unsigned FONT_LEN = 80;

  localparam logic [DW-1:0] FONT [FONT_LEN] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  typedef enum logic [2:0] {IDLE, RD_SPR, NEXT, RD_L, WR_L, RD_R, WR_R} state_e;

  // Font is folded in as an XOR overlay, so the array powers up as all zeros
  // yet reads back the font at FONT_BASE without any load sequence.
  function automatic logic [DW-1:0] font_at(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - FONT_BASE;
    return (off < AW'(FONT_LEN)) ? FONT[off[6:0]] : '0;
  endfunction

  logic [DW-1:0] mem_q [DEPTH];

  state_e        state_q,    state_d;
  logic          busy_q,     busy_d;
  logic          coll_q,     coll_d;
  logic          ack_q,      ack_d;
  logic [DW-1:0] rbyte_q,    rbyte_d;
  logic [DW-1:0] rdat_q;
  logic [AW-1:0] spr_addr_q, spr_addr_d;
  logic [3:0]    rows_q,     rows_d;
  logic [4:0]    sy_q,       sy_d;
  logic [2:0]    c_q,        c_d;
  logic [2:0]    k_q,        k_d;
  logic [DW-1:0] spr_q,      spr_d;
  logic [DW-1:0] old_q,      old_d;
  logic          ph_q,       ph_d;
  logic          row_done_c;

  logic [AW-1:0] raddr_c, waddr_c, l_addr_c, r_addr_c;
  logic [DW-1:0] rd_c, wdata_c, mask_l_c, mask_r_c;
  logic          we_c;

  assign mask_l_c = spr_q >> k_q;
  assign mask_r_c = DW'(spr_q << (4'd8 - 4'(k_q)));
  assign l_addr_c = SCREEN_BASE + AW'({sy_q, c_q});
  assign r_addr_c = SCREEN_BASE + AW'({sy_q, 3'(c_q + 3'd1)});
  assign rd_c     = mem_q[raddr_c] ^ font_at(raddr_c);

  // Single RAM port: CPU when idle, draw engine while busy.
  always_comb begin
    raddr_c = bus.mem_read_idx;
    we_c    = bus.mem_write;
    waddr_c = bus.mem_write_idx;
    wdata_c = bus.mem_write_byte;
    if (busy_q) begin
      we_c = 1'b0;
      unique case (state_q)
        RD_SPR: raddr_c = spr_addr_q;
        RD_L:   raddr_c = l_addr_c;
        RD_R:   raddr_c = r_addr_c;
        WR_L: begin
          we_c    = 1'b1;
          waddr_c = l_addr_c;
          wdata_c = old_q ^ mask_l_c;
        end
        WR_R: begin
          we_c    = 1'b1;
          waddr_c = r_addr_c;
          wdata_c = old_q ^ mask_r_c;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we_c) mem_q[waddr_c] <= wdata_c ^ font_at(waddr_c);
  end

  // CPU read handshake and draw-engine next state.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    coll_d     = coll_q;
    ack_d      = 1'b0;
    rbyte_d    = rbyte_q;
    spr_addr_d = spr_addr_q;
    rows_d     = rows_q;
    sy_d       = sy_q;
    c_d        = c_q;
    k_d        = k_q;
    spr_d      = spr_q;
    old_d      = old_q;
    ph_d       = ph_q;
    row_done_c = 1'b0;

    if (!busy_q && bus.mem_read && !ack_q) begin
      ack_d   = 1'b1;
      rbyte_d = rd_c;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.draw) begin
          state_d    = RD_SPR;
          busy_d     = 1'b1;
          coll_d     = 1'b0;
          spr_addr_d = bus.addr;
          rows_d     = bus.lines;
          sy_d       = bus.y;
          c_d        = bus.x[5:3];
          k_d        = bus.x[2:0];
          ph_d       = 1'b0;
        end
      end
      RD_SPR: begin
        if (rows_q == 4'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        spr_d   = rdat_q;
        state_d = RD_L;
      end
      RD_L: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          old_d   = rdat_q;
          state_d = WR_L;
        end
      end
      WR_L: begin
        coll_d = coll_q | (|(old_q & mask_l_c));
        if (k_q != 3'd0) state_d = RD_R;
        else             row_done_c = 1'b1;
      end
      RD_R: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          old_d   = rdat_q;
          state_d = WR_R;
        end
      end
      WR_R: begin
        coll_d     = coll_q | (|(old_q & mask_r_c));
        row_done_c = 1'b1;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Sprite address wraps mod 4096, screen row mod 32.
    if (row_done_c) begin
      rows_d     = rows_q - 4'd1;
      spr_addr_d = spr_addr_q + 12'd1;
      sy_d       = sy_q + 5'd1;
      if (rows_q == 4'd1) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end else begin
        state_d = RD_SPR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      coll_q     <= 1'b0;
      ack_q      <= 1'b0;
      rbyte_q    <= '0;
      rdat_q     <= '0;
      spr_addr_q <= '0;
      rows_q     <= '0;
      sy_q       <= '0;
      c_q        <= '0;
      k_q        <= '0;
      spr_q      <= '0;
      old_q      <= '0;
      ph_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      coll_q     <= coll_d;
      ack_q      <= ack_d;
      rbyte_q    <= rbyte_d;
      rdat_q     <= rd_c;
      spr_addr_q <= spr_addr_d;
      rows_q     <= rows_d;
      sy_q       <= sy_d;
      c_q        <= c_d;
      k_q        <= k_d;
      spr_q      <= spr_d;
      old_q      <= old_d;
      ph_q       <= ph_d;
    end
  end

  assign bus.mem_read_byte = rbyte_q;
  assign bus.mem_read_ack  = ack_q;
  assign bus.busy          = busy_q;
  assign bus.collision     = coll_q;

  assign bus.bcd_1 = 2'(bus.bcd_in / 8'd100);
  assign bus.bcd_2 = 4'((bus.bcd_in / 8'd10) % 8'd10);
  assign bus.bcd_3 = 4'(bus.bcd_in % 8'd10);

endmodule

// File: tb/tb_chip8_mem_gfx.sv
// Bench for chip8_mem_gfx: vector tables, directed draw sequences and random
// draws checked against a pixel-level frame-buffer model.
module tb_chip8_mem_gfx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chip8_mem_gfx_if bus ();

  chip8_mem_gfx #(.FONT_BASE(12'h030), .SCREEN_BASE(12'h100)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  localparam logic [7:0] FONT_TB [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  typedef struct { logic [7:0] v; logic [1:0] h; logic [3:0] t; logic [3:0] o; } bcd_vec_t;
  typedef struct { logic [11:0] a; logic [7:0] d; } rd_vec_t;

  bcd_vec_t   bcd_tab [6];
  rd_vec_t    rd_tab  [6];
  logic [7:0] ref_mem [4096];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
    bus.mem_write = 1'b1; bus.mem_write_idx = a; bus.mem_write_byte = d;
    @(posedge clk); #1;
    bus.mem_write = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic cpu_read(input logic [11:0] a, output logic [7:0] d);
    int n;
    bus.mem_read = 1'b1; bus.mem_read_idx = a;
    n = 0;
    d = 8'h00;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.mem_read_ack && n < 10);
    bus.mem_read = 1'b0;
    if (bus.mem_read_ack) d = bus.mem_read_byte;
    else begin
      n_tests++; n_fail++;
      $display("FAIL read_timeout: no ack for addr %0h within %0d cycles", a, n);
    end
  endtask

  task automatic run_draw(input logic [11:0] a, input logic [3:0] l, input logic [5:0] x,
                          input logic [4:0] y, output int cyc, output logic col);
    bus.addr = a; bus.lines = l; bus.x = x; bus.y = y; bus.draw = 1'b1;
    @(posedge clk); #1;
    bus.draw = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 400) begin
      cyc++;
      @(posedge clk); #1;
    end
    if (bus.busy) begin
      n_tests++; n_fail++;
      $display("FAIL draw_timeout: busy still high after %0d cycles, want low", cyc);
    end
    col = bus.collision;
  endtask

  // Pixel-by-pixel XOR draw on the reference frame buffer.
  function automatic logic model_draw(input logic [11:0] a, input int l, input int x, input int y);
    logic c;
    logic [7:0] s;
    int px, py, idx, b;
    c = 1'b0;
    for (int r = 0; r < l; r++) begin
      s = ref_mem[(int'(a) + r) % 4096];
      for (int i = 0; i < 8; i++) begin
        if (s[7-i]) begin
          px  = (x + i) % 64;
          py  = (y + r) % 32;
          idx = 256 + py * 8 + px / 8;
          b   = 7 - (px % 8);
          if (ref_mem[idx][b]) c = 1'b1;
          ref_mem[idx][b] = ~ref_mem[idx][b];
        end
      end
    end
    return c;
  endfunction

  function automatic int exp_cycles(input int l, input int x);
    return l * (((x % 8) != 0) ? 8 : 5);
  endfunction

  initial begin
    logic [7:0]  d;
    logic        col, mcol;
    int          cyc;
    int          h, t, o, v;
    logic [11:0] a;
    logic [3:0]  l;
    logic [5:0]  x;
    logic [4:0]  y;
    logic [11:0] wa [8];
    logic [7:0]  wd [8];

    bcd_tab[0] = '{8'd0,   2'd0, 4'd0, 4'd0};
    bcd_tab[1] = '{8'd128, 2'd1, 4'd2, 4'd8};
    bcd_tab[2] = '{8'd255, 2'd2, 4'd5, 4'd5};
    bcd_tab[3] = '{8'd9,   2'd0, 4'd0, 4'd9};
    bcd_tab[4] = '{8'd100, 2'd1, 4'd0, 4'd0};
    bcd_tab[5] = '{8'd99,  2'd0, 4'd9, 4'd9};
    rd_tab[0]  = '{12'h030, 8'hF0};
    rd_tab[1]  = '{12'h031, 8'h90};
    rd_tab[2]  = '{12'h035, 8'h20};
    rd_tab[3]  = '{12'h07F, 8'h80};
    rd_tab[4]  = '{12'h080, 8'h00};
    rd_tab[5]  = '{12'h02F, 8'h00};

    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 80; i++) ref_mem[48 + i] = FONT_TB[i];

    bus.mem_read = 1'b0; bus.mem_read_idx = '0;
    bus.mem_write = 1'b0; bus.mem_write_idx = '0; bus.mem_write_byte = '0;
    bus.bcd_in = '0; bus.draw = 1'b0; bus.addr = '0; bus.lines = '0; bus.x = '0; bus.y = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ack",  bus.mem_read_ack,  0);
    check("reset_byte", bus.mem_read_byte, 0);
    check("reset_busy", bus.busy,          0);
    check("reset_coll", bus.collision,     0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Held request: ack for one cycle, then another completion two cycles later.
    bus.mem_read = 1'b1; bus.mem_read_idx = 12'h030;
    @(posedge clk); #1;
    check("hs_ack1",  bus.mem_read_ack,  1);
    check("hs_data1", bus.mem_read_byte, 8'hF0);
    @(posedge clk); #1;
    check("hs_ack_drop", bus.mem_read_ack,  0);
    check("hs_hold",     bus.mem_read_byte, 8'hF0);
    @(posedge clk); #1;
    check("hs_ack2", bus.mem_read_ack, 1);
    bus.mem_read = 1'b0;
    @(posedge clk); #1;
    check("hs_idle", bus.mem_read_ack, 0);

    foreach (rd_tab[i]) begin
      cpu_read(rd_tab[i].a, d);
      check($sformatf("font_rd_%0h", rd_tab[i].a), d, rd_tab[i].d);
    end

    cpu_write(12'h200, 8'h5A);
    cpu_read(12'h200, d); check("wr_rd_200", d, 8'h5A);
    cpu_read(12'h201, d); check("rd_201",    d, 8'h00);

    // Same-edge read and write of one address returns the old byte.
    bus.mem_read = 1'b1; bus.mem_read_idx = 12'h210;
    bus.mem_write = 1'b1; bus.mem_write_idx = 12'h210; bus.mem_write_byte = 8'h33;
    @(posedge clk); #1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    ref_mem[12'h210] = 8'h33;
    check("rw_same_old", bus.mem_read_byte, 8'h00);
    @(posedge clk); #1;
    cpu_read(12'h210, d); check("rw_same_new", d, 8'h33);

    foreach (bcd_tab[i]) begin
      bus.bcd_in = bcd_tab[i].v; #1;
      check($sformatf("bcd_h_%0d", bcd_tab[i].v), bus.bcd_1, bcd_tab[i].h);
      check($sformatf("bcd_t_%0d", bcd_tab[i].v), bus.bcd_2, bcd_tab[i].t);
      check($sformatf("bcd_o_%0d", bcd_tab[i].v), bus.bcd_3, bcd_tab[i].o);
    end
    for (int i = 0; i < 16; i++) begin
      v = int'($urandom_range(0, 255));
      bus.bcd_in = 8'(v); #1;
      h = 0; t = 0;
      while (v >= 100) begin v -= 100; h++; end
      while (v >= 10)  begin v -= 10;  t++; end
      o = v;
      check("bcd_rand_h", bus.bcd_1, h);
      check("bcd_rand_t", bus.bcd_2, t);
      check("bcd_rand_o", bus.bcd_3, o);
    end

    for (int i = 0; i < 8; i++) begin
      wa[i] = 12'($urandom_range(12'h200, 12'hFFF));
      wd[i] = 8'($urandom);
      cpu_write(wa[i], wd[i]);
    end
    for (int i = 0; i < 8; i++) begin
      cpu_read(wa[i], d);
      check("rand_wr_rd", d, ref_mem[wa[i]]);
    end

    // Aligned draw, then the same draw again erases it and collides.
    cpu_write(12'h300, 8'hF0);
    mcol = model_draw(12'h300, 1, 0, 0);
    run_draw(12'h300, 4'd1, 6'd0, 5'd0, cyc, col);
    check("al_cycles", cyc, 5);
    check("al_coll",   col, 0);
    cpu_read(12'h100, d); check("al_100", d, 8'hF0);
    mcol = model_draw(12'h300, 1, 0, 0);
    run_draw(12'h300, 4'd1, 6'd0, 5'd0, cyc, col);
    check("al2_coll", col, 1);
    cpu_read(12'h100, d); check("al2_100", d, 8'h00);

    // Unaligned draws, including the horizontal wrap at x=60.
    cpu_write(12'h310, 8'hFF);
    mcol = model_draw(12'h310, 1, 4, 0);
    run_draw(12'h310, 4'd1, 6'd4, 5'd0, cyc, col);
    check("ua_cycles", cyc, 8);
    check("ua_coll",   col, 0);
    cpu_read(12'h100, d); check("ua_100", d, 8'h0F);
    cpu_read(12'h101, d); check("ua_101", d, 8'hF0);
    mcol = model_draw(12'h310, 1, 60, 0);
    run_draw(12'h310, 4'd1, 6'd60, 5'd0, cyc, col);
    check("hw_coll", col, 0);
    cpu_read(12'h107, d); check("hw_107", d, 8'h0F);
    cpu_read(12'h100, d); check("hw_100", d, 8'hFF);

    // Vertical wrap from row 31 to row 0; collision is sticky after busy falls.
    cpu_write(12'h320, 8'h80);
    cpu_write(12'h321, 8'h80);
    mcol = model_draw(12'h320, 2, 0, 31);
    run_draw(12'h320, 4'd2, 6'd0, 5'd31, cyc, col);
    check("vw_cycles", cyc, 10);
    check("vw_coll",   col, 1);
    repeat (3) @(posedge clk);
    #1;
    check("vw_coll_hold", bus.collision, 1);
    cpu_read(12'h1F8, d); check("vw_1f8", d, 8'h80);
    cpu_read(12'h100, d); check("vw_100", d, 8'h7F);

    run_draw(12'h320, 4'd0, 6'd0, 5'd0, cyc, col);
    check("l0_coll", col, 0);
    cpu_read(12'h100, d); check("l0_100", d, 8'h7F);
    cpu_read(12'h1F8, d); check("l0_1f8", d, 8'h80);

    // Random draws checked against the frame-buffer model.
    for (int n = 0; n < 12; n++) begin
      a = 12'($urandom_range(12'h300, 12'hEF0));
      l = 4'($urandom_range(1, 15));
      x = 6'($urandom);
      y = 5'($urandom);
      for (int r = 0; r < int'(l); r++) cpu_write(a + 12'(r), 8'($urandom));
      mcol = model_draw(a, int'(l), int'(x), int'(y));
      run_draw(a, l, x, y, cyc, col);
      check($sformatf("rnd%0d_cycles", n), cyc, exp_cycles(int'(l), int'(x)));
      check($sformatf("rnd%0d_coll", n),   col, mcol);
      for (int i = 0; i < 256; i++) begin
        cpu_read(12'h100 + 12'(i), d);
        check($sformatf("rnd%0d_scr_%0h", n, 12'h100 + 12'(i)), d, ref_mem[12'h100 + 12'(i)]);
      end
    end

    // Reset in the middle of a long draw aborts it.
    bus.addr = 12'h300; bus.lines = 4'd15; bus.x = 6'd3; bus.y = 5'd0; bus.draw = 1'b1;
    @(posedge clk); #1;
    bus.draw = 1'b0;
    check("abort_busy_pre", bus.busy, 1);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_coll", bus.collision, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_still_idle", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
